// File: rtl/fft_r2_ctrl_if.sv
// fft_r2_ctrl_if
// Control/status bundle between the radix-2 FFT sequencer and its
// two-bank butterfly datapath.
//   master : the controller (drives strobes, addresses, swaps, twiddle, status)
//   slave  : the datapath / host side (drives start and the global enable valid)
// Signals:
//   start, valid                      host -> controller
//   busy, done, input_done, stage     status
//   in_bank                           bank of the current load sample
//   we_b*/re_b*, waddr_b*/raddr_b*    bank strobes and addresses
//   swap0_en, swap1_en, tw_addr       datapath steering
//   out_valid, out_sel                unload data qualifiers
interface fft_r2_ctrl_if #(
    parameter int LOG2N = 6
);
    localparam int AW = LOG2N - 1;
    localparam int SW = $clog2(LOG2N + 1);

    logic          start;
    logic          valid;
    logic          busy;
    logic          done;
    logic          input_done;
    logic          in_bank;
    logic          we_b0;
    logic          we_b1;
    logic          re_b0;
    logic          re_b1;
    logic [AW-1:0] waddr_b0;
    logic [AW-1:0] waddr_b1;
    logic [AW-1:0] raddr_b0;
    logic [AW-1:0] raddr_b1;
    logic          swap0_en;
    logic          swap1_en;
    logic [AW-1:0] tw_addr;
    logic [SW-1:0] stage;
    logic          out_valid;
    logic          out_sel;

    modport master (
        input  start, valid,
        output busy, done, input_done, in_bank,
        output we_b0, we_b1, re_b0, re_b1,
        output waddr_b0, waddr_b1, raddr_b0, raddr_b1,
        output swap0_en, swap1_en, tw_addr, stage,
        output out_valid, out_sel
    );

    modport slave (
        output start, valid,
        input  busy, done, input_done, in_bank,
        input  we_b0, we_b1, re_b0, re_b1,
        input  waddr_b0, waddr_b1, raddr_b0, raddr_b1,
        input  swap0_en, swap1_en, tw_addr, stage,
        input  out_valid, out_sel
    );
endinterface

// File: rtl/fft_r2_ctrl.sv
// fft_r2_ctrl
// Sequencer for an in-place radix-2 DIF FFT over two dual-port SRAM banks.
// Point i lives in bank XOR-reduce(i) at address i>>1, so the two operands
// of every butterfly always sit in different banks.
// Phases: LOAD (N writes), LOG2N x {COMPUTE (N/2 reads), DRAIN (BF_LAT+1
// idle cycles)}, UNLOAD (N reads), then a one-cycle done pulse.
// Ports:
//   clk  - clock, rising edge
//   nrst - synchronous active-low reset
//   bus  - fft_r2_ctrl_if.master (strobes, addresses, swaps, twiddle, status)
// Parameters: LOG2N (log2 of length, >= 2), BF_LAT (butterfly latency, >= 1).
// Optional feature macro: FFT_CTRL_NATURAL_ORDER_EN -- when defined, UNLOAD
// reads in bit-reversed address order so results leave in natural order.
// valid is a global enable: with valid=0 nothing advances and all
// strobes/pulses (re, we, out_valid, done) are forced low.
module fft_r2_ctrl #(
    parameter int LOG2N  = 6,
    parameter int BF_LAT = 3
) (
    input  logic          clk,
    input  logic          nrst,
    fft_r2_ctrl_if.master bus
);
    localparam int AW = LOG2N - 1;
    localparam int N  = 1 << LOG2N;
    localparam int SW = $clog2(LOG2N + 1);
    localparam int BW = $clog2(BF_LAT + 1);
    localparam int CW = (LOG2N > BW) ? LOG2N : BW;
    localparam int PD = BF_LAT + 1;        // read-issue to write-back distance
    localparam int PW = 3 + 2 * AW;        // {re0, re1, swap, addr0, addr1}

    typedef enum logic [2:0] {IDLE, LOAD, COMPUTE, DRAIN, UNLOAD} state_t;

    state_t        state_reg, state_next;
    logic [CW-1:0] cnt_reg, cnt_next;
    logic [SW-1:0] stage_reg, stage_next;
    logic          done_reg, done_next;
    logic          swap0_reg;
    logic [AW-1:0] tw_reg;
    logic          out_valid_reg;
    logic          out_sel_reg;
    logic [PD-1:0][PW-1:0] pipe_reg;

    logic          en;
    assign en = bus.valid;

    // ---------------- FSM ----------------
    always_ff @(posedge clk) begin
        if (!nrst) begin
            state_reg <= IDLE;
            cnt_reg   <= '0;
            stage_reg <= '0;
        end else if (en) begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
            stage_reg <= stage_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        stage_next = stage_reg;
        done_next  = 1'b0;
        unique case (state_reg)
            IDLE: begin
                if (bus.start) begin
                    state_next = LOAD;
                    cnt_next   = '0;
                    stage_next = '0;
                end
            end
            LOAD: begin
                if (cnt_reg == CW'(N - 1)) begin
                    state_next = COMPUTE;
                    cnt_next   = '0;
                    stage_next = '0;
                end else begin
                    cnt_next = cnt_reg + 1'b1;
                end
            end
            COMPUTE: begin
                if (cnt_reg == CW'(N / 2 - 1)) begin
                    state_next = DRAIN;
                    cnt_next   = '0;
                end else begin
                    cnt_next = cnt_reg + 1'b1;
                end
            end
            DRAIN: begin
                // BF_LAT+1 idle cycles let the final write-back of this
                // stage land before the next stage reads the same words.
                if (cnt_reg == CW'(BF_LAT)) begin
                    cnt_next = '0;
                    if (stage_reg == SW'(LOG2N - 1)) begin
                        state_next = UNLOAD;
                    end else begin
                        state_next = COMPUTE;
                        stage_next = stage_reg + 1'b1;
                    end
                end else begin
                    cnt_next = cnt_reg + 1'b1;
                end
            end
            UNLOAD: begin
                if (cnt_reg == CW'(N - 1)) begin
                    state_next = IDLE;
                    cnt_next   = '0;
                    stage_next = '0;
                    done_next  = 1'b1;
                end else begin
                    cnt_next = cnt_reg + 1'b1;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // ---------------- butterfly operand addressing ----------------
    // a = k with a zero inserted at bit p = LOG2N-1-stage; b = a + 2**p.
    // Bit p of a is zero, so the add is just an OR.
    logic [SW-1:0]    shift_p;
    logic [LOG2N-1:0] kx, lo_mask, a_idx, b_idx;
    logic [AW-1:0]    tw_calc;

    assign shift_p = SW'(LOG2N - 1) - stage_reg;
    assign kx      = {1'b0, cnt_reg[AW-1:0]};
    assign lo_mask = (LOG2N'(1) << shift_p) - LOG2N'(1);
    assign a_idx   = ((kx & ~lo_mask) << 1) | (kx & lo_mask);
    assign b_idx   = a_idx | (LOG2N'(1) << shift_p);
    assign tw_calc = AW'((kx & lo_mask) << stage_reg);

    // Unload index: memory order by default, bit-reversed for natural order.
    logic [LOG2N-1:0] u_idx;
`ifdef FFT_CTRL_NATURAL_ORDER_EN
    generate
        for (genvar gi = 0; gi < LOG2N; gi++) begin : g_rev
            assign u_idx[gi] = cnt_reg[LOG2N-1-gi];
        end
    endgenerate
`else
    assign u_idx = cnt_reg[LOG2N-1:0];
`endif

    // ---------------- read issue ----------------
    logic          rd_re0, rd_re1, rd_swap;
    logic [AW-1:0] rd_a0, rd_a1;
    logic [PW-1:0] pipe_in;

    always_comb begin
        rd_re0  = 1'b0;
        rd_re1  = 1'b0;
        rd_swap = 1'b0;
        rd_a0   = '0;
        rd_a1   = '0;
        pipe_in = '0;
        unique case (state_reg)
            COMPUTE: begin
                rd_re0  = 1'b1;
                rd_re1  = 1'b1;
                rd_swap = ^a_idx;
                if (rd_swap) begin
                    rd_a0 = b_idx[LOG2N-1:1];
                    rd_a1 = a_idx[LOG2N-1:1];
                end else begin
                    rd_a0 = a_idx[LOG2N-1:1];
                    rd_a1 = b_idx[LOG2N-1:1];
                end
                // Only butterfly reads feed the write-back pipe; unload
                // reads must never turn into writes.
                pipe_in = {1'b1, 1'b1, rd_swap, rd_a0, rd_a1};
            end
            UNLOAD: begin
                if (^u_idx) begin
                    rd_re1 = 1'b1;
                    rd_a1  = u_idx[LOG2N-1:1];
                end else begin
                    rd_re0 = 1'b1;
                    rd_a0  = u_idx[LOG2N-1:1];
                end
            end
            default: ;
        endcase
    end

    // ---------------- registered read-side and write-back pipe ----------------
    always_ff @(posedge clk) begin
        if (!nrst) begin
            swap0_reg     <= 1'b0;
            tw_reg        <= '0;
            out_valid_reg <= 1'b0;
            out_sel_reg   <= 1'b0;
            done_reg      <= 1'b0;
            pipe_reg      <= '0;
        end else if (en) begin
            swap0_reg     <= rd_swap;
            tw_reg        <= (state_reg == COMPUTE) ? tw_calc : '0;
            out_valid_reg <= (state_reg == UNLOAD);
            out_sel_reg   <= (state_reg == UNLOAD) & (^u_idx);
            done_reg      <= done_next;
            pipe_reg[0]   <= pipe_in;
            for (int i = 1; i < PD; i++) begin
                pipe_reg[i] <= pipe_reg[i-1];
            end
        end
    end

    logic [PW-1:0] pipe_out;
    logic          wb_re0, wb_re1, wb_swap;
    logic [AW-1:0] wb_a0, wb_a1;
    assign pipe_out = pipe_reg[PD-1];
    assign wb_re0   = pipe_out[PW-1];
    assign wb_re1   = pipe_out[PW-2];
    assign wb_swap  = pipe_out[PW-3];
    assign wb_a0    = pipe_out[2*AW-1:AW];
    assign wb_a1    = pipe_out[AW-1:0];

    // LOAD writes go straight to the bank; the pipe is empty during LOAD.
    logic ld_act, ld_bank;
    assign ld_act  = (state_reg == LOAD);
    assign ld_bank = ^cnt_reg[LOG2N-1:0];

    // ---------------- outputs ----------------
    assign bus.busy       = (state_reg != IDLE);
    assign bus.done       = en & done_reg;
    assign bus.input_done = (state_reg == COMPUTE) || (state_reg == DRAIN) ||
                            (state_reg == UNLOAD);
    assign bus.in_bank    = ld_act & ld_bank;
    assign bus.we_b0      = en & ((ld_act & ~ld_bank) | wb_re0);
    assign bus.we_b1      = en & ((ld_act & ld_bank) | wb_re1);
    assign bus.waddr_b0   = ld_act ? cnt_reg[LOG2N-1:1] : wb_a0;
    assign bus.waddr_b1   = ld_act ? cnt_reg[LOG2N-1:1] : wb_a1;
    assign bus.re_b0      = en & rd_re0;
    assign bus.re_b1      = en & rd_re1;
    assign bus.raddr_b0   = rd_a0;
    assign bus.raddr_b1   = rd_a1;
    assign bus.swap0_en   = swap0_reg;
    assign bus.swap1_en   = wb_swap;
    assign bus.tw_addr    = tw_reg;
    assign bus.stage      = stage_reg;
    assign bus.out_valid  = en & out_valid_reg;
    assign bus.out_sel    = out_sel_reg;
endmodule

// File: tb/tb_fft_r2_ctrl.sv
// tb_fft_r2_ctrl
// Directed bench for fft_r2_ctrl at default parameters (N=64, BF_LAT=3).
// Cycle c counts rising edges since the edge that accepted start (c=1 is
// LOAD sample 0). Hand-computed vectors {cycle, signal, value} are checked
// during a full valid=1 run, followed by a valid-toggling run compared
// against the compressed trace and a reset in the middle of COMPUTE.
module tb_fft_r2_ctrl;
    localparam int LOG2N  = 6;
    localparam int BF_LAT = 3;
    localparam int N      = 1 << LOG2N;
    localparam int C_CMP0 = N + 1;              // first butterfly read
    localparam int STG    = N / 2 + BF_LAT + 1; // cycles per stage incl. drain
    localparam int TOTAL  = 345;

    localparam int S_RE0 = 0,  S_RE1 = 1,  S_RA0 = 2,  S_RA1 = 3;
    localparam int S_WE0 = 4,  S_WE1 = 5,  S_WA0 = 6,  S_WA1 = 7;
    localparam int S_SW0 = 8,  S_SW1 = 9,  S_TW  = 10, S_INB = 11;
    localparam int S_OV  = 12, S_OS  = 13, S_DONE = 14, S_BUSY = 15;
    localparam int S_STG = 16, S_IDN = 17;

    typedef struct {
        int cyc;
        int sig;
        int exp;
    } vec_t;

    logic clk;
    logic nrst;
    int   total;
    int   bad;
    vec_t vecs[$];
    logic [33:0] trace [0:TOTAL-1];

    fft_r2_ctrl_if #(.LOG2N(LOG2N)) bus ();

    fft_r2_ctrl #(.LOG2N(LOG2N), .BF_LAT(BF_LAT)) dut (
        .clk (clk),
        .nrst(nrst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic int get_sig(input int s);
        case (s)
            S_RE0:  return int'(bus.re_b0);
            S_RE1:  return int'(bus.re_b1);
            S_RA0:  return int'(bus.raddr_b0);
            S_RA1:  return int'(bus.raddr_b1);
            S_WE0:  return int'(bus.we_b0);
            S_WE1:  return int'(bus.we_b1);
            S_WA0:  return int'(bus.waddr_b0);
            S_WA1:  return int'(bus.waddr_b1);
            S_SW0:  return int'(bus.swap0_en);
            S_SW1:  return int'(bus.swap1_en);
            S_TW:   return int'(bus.tw_addr);
            S_INB:  return int'(bus.in_bank);
            S_OV:   return int'(bus.out_valid);
            S_OS:   return int'(bus.out_sel);
            S_DONE: return int'(bus.done);
            S_BUSY: return int'(bus.busy);
            S_STG:  return int'(bus.stage);
            default: return int'(bus.input_done);
        endcase
    endfunction

    function automatic string sig_name(input int s);
        case (s)
            S_RE0: return "re_b0";     S_RE1: return "re_b1";
            S_RA0: return "raddr_b0";  S_RA1: return "raddr_b1";
            S_WE0: return "we_b0";     S_WE1: return "we_b1";
            S_WA0: return "waddr_b0";  S_WA1: return "waddr_b1";
            S_SW0: return "swap0_en";  S_SW1: return "swap1_en";
            S_TW:  return "tw_addr";   S_INB: return "in_bank";
            S_OV:  return "out_valid"; S_OS:  return "out_sel";
            S_DONE: return "done";     S_BUSY: return "busy";
            S_STG: return "stage";
            default: return "input_done";
        endcase
    endfunction

    function automatic logic [33:0] pack_outs();
        return {bus.re_b0, bus.re_b1, bus.we_b0, bus.we_b1, bus.done,
                bus.out_valid, bus.out_sel, bus.swap0_en, bus.swap1_en,
                bus.raddr_b0, bus.raddr_b1, bus.waddr_b0, bus.waddr_b1, bus.tw_addr};
    endfunction

    task automatic add(input int c, input int s, input int e);
        vec_t v;
        v.cyc = c;
        v.sig = s;
        v.exp = e;
        vecs.push_back(v);
    endtask

    initial begin
        int done_at;
        int wc0;
        int wc1;
        int n;
        int guard;
        string nm;

        total = 0;
        bad   = 0;

        // ---- vector table ----
        // LOAD: sample c-1 -> bank par, address (c-1)>>1
        add(1, S_WE0, 1);  add(1, S_WE1, 0);  add(1, S_WA0, 0);  add(1, S_INB, 0);
        add(1, S_BUSY, 1); add(1, S_IDN, 0);
        add(2, S_WE1, 1);  add(2, S_WE0, 0);  add(2, S_WA1, 0);  add(2, S_INB, 1);
        add(8, S_WE1, 1);  add(8, S_WA1, 3);  add(8, S_INB, 1);
        add(64, S_WE0, 1); add(64, S_WA0, 31); add(64, S_INB, 0);
        // stage 0: k=0 (a=0,b=32), k=1 (a=1,b=33 swapped), k=5 (a=5,b=37)
        add(65, S_RE0, 1); add(65, S_RE1, 1); add(65, S_RA0, 0); add(65, S_RA1, 16);
        add(65, S_STG, 0); add(65, S_IDN, 1); add(65, S_WE0, 0);
        add(66, S_RA0, 16); add(66, S_RA1, 0);
        add(67, S_SW0, 1); add(67, S_TW, 1);
        add(68, S_WE0, 0);
        add(69, S_WE0, 1); add(69, S_WE1, 1); add(69, S_WA0, 0); add(69, S_WA1, 16); add(69, S_SW1, 0);
        add(70, S_WA0, 16); add(70, S_WA1, 0); add(70, S_SW1, 1);
        add(70, S_RA0, 2); add(70, S_RA1, 18);
        add(71, S_SW0, 0); add(71, S_TW, 5);
        add(74, S_WE0, 1); add(74, S_WE1, 1); add(74, S_WA0, 2); add(74, S_WA1, 18); add(74, S_SW1, 0);
        // stage 0 drain and stage 1 start
        add(97, S_RE0, 0); add(97, S_RE1, 0); add(97, S_IDN, 1);
        add(100, S_WE0, 1);
        add(101, S_WE0, 0); add(101, S_RE0, 1); add(101, S_STG, 1);
        add(101, S_RA0, 0); add(101, S_RA1, 8);
        // stage 1 k=17 (a=33,b=49); stage 5 k=3 (a=6,b=7)
        add(118, S_RA0, 16); add(118, S_RA1, 24); add(118, S_STG, 1);
        add(119, S_TW, 2);
        add(248, S_RA0, 3); add(248, S_RA1, 3); add(248, S_STG, 5);
        add(249, S_TW, 0); add(249, S_SW0, 0);
        add(280, S_WE0, 1);
        // UNLOAD
        add(281, S_RE0, 1); add(281, S_RE1, 0); add(281, S_RA0, 0);
        add(281, S_WE0, 0); add(281, S_WE1, 0); add(281, S_OV, 0);
        add(282, S_RE1, 1); add(282, S_RE0, 0);
`ifdef FFT_CTRL_NATURAL_ORDER_EN
        add(282, S_RA1, 16);
`else
        add(282, S_RA1, 0);
`endif
        add(282, S_OV, 1); add(282, S_OS, 0);
        add(283, S_OV, 1); add(283, S_OS, 1);
        add(344, S_RE0, 1); add(344, S_RA0, 31); add(344, S_DONE, 0); add(344, S_BUSY, 1);
        add(345, S_DONE, 1); add(345, S_OV, 1); add(345, S_OS, 0); add(345, S_BUSY, 0);
        add(345, S_IDN, 0); add(345, S_RE0, 0);
        add(346, S_DONE, 0); add(346, S_OV, 0);

        // ---- reset ----
        nrst      = 1'b0;
        bus.start = 1'b0;
        bus.valid = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("rst busy", bus.busy, 0);
        check("rst done", bus.done, 0);
        check("rst re", {bus.re_b0, bus.re_b1}, 0);
        check("rst we", {bus.we_b0, bus.we_b1}, 0);
        check("rst addr", {bus.raddr_b0, bus.raddr_b1, bus.waddr_b0, bus.waddr_b1}, 0);
        check("rst tw_addr", bus.tw_addr, 0);
        check("rst stage", bus.stage, 0);
        check("rst swaps", {bus.swap0_en, bus.swap1_en}, 0);
        check("rst out", {bus.out_valid, bus.out_sel, bus.input_done, bus.in_bank}, 0);
        nrst = 1'b1;
        @(posedge clk);
        #1;

        // ---- run 1: valid held high ----
        bus.start = 1'b1;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        done_at = 0;
        wc0 = 0;
        wc1 = 0;
        for (int c = 1; c <= TOTAL + 1; c++) begin
            foreach (vecs[i]) begin
                if (vecs[i].cyc == c) begin
                    nm = $sformatf("c=%0d %s", c, sig_name(vecs[i].sig));
                    $display("vec %s got %0d want %0d", nm, get_sig(vecs[i].sig), vecs[i].exp);
                    check(nm, get_sig(vecs[i].sig), vecs[i].exp);
                end
            end
            // every write of the previous stage must have landed by the
            // first read of the next stage (32 load writes per bank first)
            for (int s = 1; s < LOG2N; s++) begin
                if (c == C_CMP0 + STG * s) begin
                    check($sformatf("hazard b0 stage %0d", s), wc0, 32 + 32 * s);
                    check($sformatf("hazard b1 stage %0d", s), wc1, 32 + 32 * s);
                end
            end
            if (bus.we_b0) wc0++;
            if (bus.we_b1) wc1++;
            if (c <= TOTAL) trace[c-1] = pack_outs();
            if (bus.done && done_at == 0) done_at = c;
            @(posedge clk);
            #1;
        end
        $display("run1 done_at=%0d writes b0=%0d b1=%0d", done_at, wc0, wc1);
        check("done cycle", done_at, TOTAL);
        check("total writes b0", wc0, 32 + 32 * LOG2N);
        check("total writes b1", wc1, 32 + 32 * LOG2N);

        // ---- run 2: random valid, compressed trace must match run 1 ----
        bus.start = 1'b1;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        n = 0;
        guard = 0;
        while (n < TOTAL && guard < 4000) begin
            bus.valid = ($urandom_range(0, 3) != 0);
            #1;
            if (bus.valid) begin
                check($sformatf("trace %0d", n), pack_outs(), trace[n]);
                n++;
            end else begin
                check("gated strobes",
                      {bus.re_b0, bus.re_b1, bus.we_b0, bus.we_b1, bus.done, bus.out_valid}, 0);
            end
            @(posedge clk);
            #1;
            guard++;
        end
        bus.valid = 1'b1;
        $display("run2 entries=%0d cycles=%0d", n, guard);
        check("run2 completes", n, TOTAL);
        @(posedge clk);
        #1;

        // ---- run 3: reset in the middle of COMPUTE ----
        bus.start = 1'b1;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        repeat (79) @(posedge clk);
        #1;
        check("mid busy", bus.busy, 1);
        check("mid write pending", {bus.we_b0, bus.we_b1}, 2'b11);
        nrst = 1'b0;
        @(posedge clk);
        #1;
        nrst = 1'b1;
        check("abort busy", bus.busy, 0);
        check("abort strobes", {bus.re_b0, bus.re_b1, bus.we_b0, bus.we_b1}, 0);
        check("abort stage", bus.stage, 0);
        check("abort input_done", bus.input_done, 0);
        for (int i = 0; i < BF_LAT + 2; i++) begin
            @(posedge clk);
            #1;
            check($sformatf("post-abort we %0d", i), {bus.we_b0, bus.we_b1}, 0);
            check($sformatf("post-abort busy %0d", i), bus.busy, 0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
